clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 6 +
 rtl/clk_div_ch.sv | 81 ++++++++
 rtl/clk_div_multi.sv | 36 +++
 tb/tb_clk_div_multi.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Holds the minimum legal divisor and the default post-reset divisor.
package clk_div_pkg;
   localparam int DIV_MIN      = 2;
   localparam int DEF_DIV_DFLT = 100000;
endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: registered clkout/tick, one-cycle latency from state, no backpressure.
// New divisor/high values are double-buffered and switch only at a period boundary.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int W       = 32,
   parameter int DEF_DIV = DEF_DIV_DFLT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] div_in,
   input  logic [W-1:0] hi_in,
   output logic         clkout,
   output logic         tick,
   output logic         pending
);
   logic [W-1:0] r_cnt;
   logic [W-1:0] r_div;
   logic [W-1:0] r_hi;
   logic [W-1:0] r_sh_div;
   logic [W-1:0] r_sh_hi;
   logic         r_clkout;
   logic         r_tick;
   logic         r_pend;

   logic [W-1:0] w_cap_div;
   logic [W-1:0] w_cap_hi;
   logic [W-1:0] w_cnt_n;
   logic [W-1:0] w_div_n;
   logic [W-1:0] w_hi_n;
   logic         w_wrap;
   logic         w_bound;

   // A disabled channel sits at cnt=0, so every edge while disabled is a period boundary.
   always_comb begin
      w_cap_div = (div_in < W'(DIV_MIN)) ? W'(DIV_MIN) : div_in;
      w_cap_hi  = (hi_in > w_cap_div) ? w_cap_div : hi_in;
      w_wrap    = (r_cnt == r_div - 1'b1);
      w_bound   = ~en | w_wrap;
      w_cnt_n   = w_bound ? '0 : r_cnt + 1'b1;
      w_div_n   = r_div;
      w_hi_n    = r_hi;
      if (w_bound && load) begin
         w_div_n = w_cap_div;
         w_hi_n  = w_cap_hi;
      end else if (w_bound && r_pend) begin
         w_div_n = r_sh_div;
         w_hi_n  = r_sh_hi;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_div    <= W'(DEF_DIV);
         r_hi     <= W'(DEF_DIV >> 1);
         r_sh_div <= '0;
         r_sh_hi  <= '0;
         r_clkout <= 1'b0;
         r_tick   <= 1'b0;
         r_pend   <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_n;
         r_div    <= w_div_n;
         r_hi     <= w_hi_n;
         if (load) begin
            r_sh_div <= w_cap_div;
            r_sh_hi  <= w_cap_hi;
         end
         r_pend   <= ~w_bound & (load | r_pend);
         r_clkout <= en & (w_cnt_n >= w_div_n - w_hi_n);
         r_tick   <= en & (w_cnt_n == w_div_n - 1'b1);
      end
   end

   assign clkout  = r_clkout;
   assign tick    = r_tick;
   assign pending = r_pend;
endmodule

// File: rtl/clk_div_multi.sv
// CH independent programmable clock dividers sharing one clock and reset.
// Outputs are registered per channel; there is no cross-channel interaction.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int CH      = 4,
   parameter int W       = 32,
   parameter int DEF_DIV = DEF_DIV_DFLT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH-1:0]   en,
   input  logic [CH-1:0]   load,
   input  logic [CH*W-1:0] div_in,
   input  logic [CH*W-1:0] hi_in,
   output logic [CH-1:0]   clkout,
   output logic [CH-1:0]   tick,
   output logic [CH-1:0]   pending
);
   for (genvar g = 0; g < CH; g++) begin : g_ch
      clk_div_ch #(
         .W       (W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en[g]),
         .load    (load[g]),
         .div_in  (div_in[g*W +: W]),
         .hi_in   (hi_in[g*W +: W]),
         .clkout  (clkout[g]),
         .tick    (tick[g]),
         .pending (pending[g])
      );
   end
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed and randomized checks of clk_div_multi against a per-channel period model.
module tb_clk_div_multi;
   localparam int CH = 4;
   localparam int W  = 16;
   localparam int DD = 10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CH-1:0]   en = '0;
   logic [CH-1:0]   load = '0;
   logic [CH*W-1:0] div_in = '0;
   logic [CH*W-1:0] hi_in = '0;
   logic [CH-1:0]   clkout;
   logic [CH-1:0]   tick;
   logic [CH-1:0]   pending;

   int n_vec = 0;
   int n_bad = 0;

   // Model: active period/high length, position in period, staged values.
   int m_d[CH], m_h[CH], m_cnt[CH], m_sd[CH], m_sh[CH];
   bit m_pend[CH], m_act[CH];

   clk_div_multi #(.CH(CH), .W(W), .DEF_DIV(DD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .div_in  (div_in),
      .hi_in   (hi_in),
      .clkout  (clkout),
      .tick    (tick),
      .pending (pending)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_d[c] = DD; m_h[c] = DD / 2; m_cnt[c] = 0;
         m_sd[c] = 0; m_sh[c] = 0; m_pend[c] = 0; m_act[c] = 0;
      end
   endtask

   task automatic model_step();
      int nd, nh;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int c = 0; c < CH; c++) begin
         nd = int'(div_in[c*W +: W]);
         nh = int'(hi_in[c*W +: W]);
         if (nd < 2) nd = 2;
         if (nh > nd) nh = nd;
         if (!en[c] || m_cnt[c] == m_d[c] - 1) begin
            // period boundary: newest request wins, otherwise staged values
            if (load[c]) begin m_d[c] = nd; m_h[c] = nh; end
            else if (m_pend[c]) begin m_d[c] = m_sd[c]; m_h[c] = m_sh[c]; end
            m_pend[c] = 0;
            m_cnt[c]  = 0;
         end else begin
            m_cnt[c] = m_cnt[c] + 1;
            if (load[c]) begin m_sd[c] = nd; m_sh[c] = nh; m_pend[c] = 1; end
         end
         m_act[c] = en[c];
      end
   endtask

   task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [CH-1:0] e_clk, e_tick, e_pend;
      for (int c = 0; c < CH; c++) begin
         e_clk[c]  = m_act[c] && (m_cnt[c] >= m_d[c] - m_h[c]);
         e_tick[c] = m_act[c] && (m_cnt[c] == m_d[c] - 1);
         e_pend[c] = m_pend[c];
      end
      chk({tag, ".clkout"}, clkout, e_clk);
      chk({tag, ".tick"}, tick, e_tick);
      chk({tag, ".pending"}, pending, e_pend);
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic run(input string tag, input int n);
      repeat (n) cyc(tag);
   endtask

   task automatic set_ch(input int c, input int d, input int h);
      logic [31:0] dv, hv;
      dv = d; hv = h;
      div_in[c*W +: W] = dv[W-1:0];
      hi_in[c*W +: W]  = hv[W-1:0];
   endtask

   task automatic pulse_load(input string tag, input int c, input int d, input int h);
      set_ch(c, d, h);
      load[c] = 1'b1;
      cyc(tag);
      load[c] = 1'b0;
   endtask

   task automatic wait_cnt(input string tag, input int c, input int v);
      for (int k = 0; k < 64 && m_cnt[c] != v; k++) cyc(tag);
      if (m_cnt[c] != v) begin
         n_bad++;
         $error("FAIL %s timeout waiting for cnt=%0d on ch%0d", tag, v, c);
      end
   endtask

   initial begin
      model_reset();
      #1;
      check_all("reset");

      @(negedge clk);
      rst_n = 1'b1;
      en    = '1;
      run("default_period", 25);

      wait_cnt("reload_mid", 0, 3);
      pulse_load("reload_mid", 0, 4, 1);
      run("reload_mid", 30);

      wait_cnt("reload_wrap", 0, m_d[0] - 1);
      pulse_load("reload_wrap", 0, 6, 3);
      run("reload_wrap", 20);

      pulse_load("clamp_high", 1, 1, 5);
      run("clamp_high", 20);
      pulse_load("clamp_zero", 2, 0, 0);
      run("clamp_zero", 30);

      wait_cnt("disable", 3, 7);
      en[3] = 1'b0;
      run("disable", 4);
      pulse_load("load_disabled", 3, 5, 2);
      en[3] = 1'b1;
      run("load_disabled", 20);

      en = '0;
      cyc("multi_setup");
      set_ch(0, 2, 1); set_ch(1, 3, 1); set_ch(2, 7, 3); set_ch(3, 16, 8);
      load = '1;
      cyc("multi_setup");
      load = '0;
      en   = '1;
      run("multi", 20);
      pulse_load("multi_reload", 0, 5, 2);
      run("multi", 100);

      repeat (400) begin
         for (int c = 0; c < CH; c++) begin
            en[c]   = ($urandom_range(0, 9) != 0);
            load[c] = ($urandom_range(0, 9) == 0);
            set_ch(c, $urandom_range(0, 20), $urandom_range(0, 22));
         end
         cyc("random");
      end

      en = '1;
      load = '0;
      pulse_load("async_setup", 0, 8, 4);
      for (int k = 0; k < 40 && !(m_act[0] && m_cnt[0] >= m_d[0] - m_h[0]); k++)
         cyc("async_setup");
      if (!(m_act[0] && m_cnt[0] >= m_d[0] - m_h[0])) begin
         n_bad++;
         $error("FAIL async_setup timeout waiting for clkout[0] high");
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      @(negedge clk);
      check_all("async_hold");
      rst_n = 1'b1;
      run("after_reset", 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
